// File: rtl/ps2_host_tx_pkg.sv
// PS/2 host transmitter shared definitions.
// FSM state encoding, frame size, command bytes and frame builder.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RELEASE   = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam int PS2_FRAME_BITS = 10;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // LSB first on the wire: data, odd parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0]
    make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_fall_detect.sv
// Falling-edge detector for a synchronised PS/2 clock line.
// Ports: clk, reset (async, high), i_line in; o_fall one-cycle pulse.
module ps2_fall_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_line;
  end

  assign o_fall = r_prev & ~i_line;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with ack/timeout status.
// Ports: clk, reset, ps2Clk/ps2Data in, txData/txStart request in;
// ps2ClkLow/ps2DataLow pull-low enables, txBusy, txDone, txError out.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2700,
  parameter int TIMEOUT_CYCLES = 54000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       ps2ClkLow,
  output logic       ps2DataLow,
  output logic       txBusy,
  output logic       txDone,
  output logic       txError
);

  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES)
                      ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int FB = PS2_FRAME_BITS;

  localparam logic [CW-1:0] C_INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] C_TMO      = CW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    C_LAST_BIT = 4'(FB - 1);

  state_t        r_state,    w_state;
  logic [CW-1:0] r_cnt,      w_cnt;
  logic [3:0]    r_bit_cnt,  w_bit_cnt;
  logic [FB-1:0] r_frame,    w_frame;
  logic          r_ok,       w_ok;
  logic          r_clk_low,  w_clk_low;
  logic          r_data_low, w_data_low;
  logic          r_busy,     w_busy;
  logic          r_done,     w_done;
  logic          r_err,      w_err;
  logic          w_fall;

  ps2_fall_detect u_fall (
    .clk    (clk),
    .reset  (reset),
    .i_line (ps2Clk),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_frame    <= '0;
      r_ok       <= 1'b0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_frame    <= w_frame;
      r_ok       <= w_ok;
      r_clk_low  <= w_clk_low;
      r_data_low <= w_data_low;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_bit_cnt  = r_bit_cnt;
    w_frame    = r_frame;
    w_ok       = r_ok;
    w_clk_low  = r_clk_low;
    w_data_low = r_data_low;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_err      = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_clk_low  = 1'b0;
        w_data_low = 1'b0;
        if (txStart) begin
          w_frame   = make_frame(txData);
          w_cnt     = '0;
          w_bit_cnt = '0;
          w_clk_low = 1'b1;
          w_busy    = 1'b1;
          w_state   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (r_cnt == C_INH_LAST) begin
          // Start bit goes out with the clock release.
          w_data_low = 1'b1;
          w_clk_low  = 1'b0;
          w_cnt      = '0;
          w_state    = RELEASE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RELEASE, SEND: begin
        w_clk_low = 1'b0;
        if (w_fall) begin
          w_data_low = ~r_frame[0];
          w_frame    = {1'b0, r_frame[FB-1:1]};
          w_bit_cnt  = r_bit_cnt + 1'b1;
          w_state    = (r_bit_cnt == C_LAST_BIT)
                     ? ACK : SEND;
        end
      end
      ACK: begin
        if (w_fall) begin
          w_ok    = ~ps2Data;
          w_state = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (ps2Clk && ps2Data) begin
          w_done  = r_ok;
          w_err   = ~r_ok;
          w_busy  = 1'b0;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase

    // Inter-edge watchdog once the device owns the clock.
    if (r_state inside {RELEASE, SEND, ACK, WAIT_IDLE}) begin
      if (w_fall) begin
        w_cnt = '0;
      end else if (r_cnt == C_TMO) begin
        w_clk_low  = 1'b0;
        w_data_low = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b1;
        w_busy     = 1'b0;
        w_cnt      = '0;
        w_state    = IDLE;
      end else begin
        w_cnt = r_cnt + 1'b1;
      end
    end
  end

  assign ps2ClkLow  = r_clk_low;
  assign ps2DataLow = r_data_low;
  assign txBusy     = r_busy;
  assign txDone     = r_done;
  assign txError    = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device.
// Expected results are queued at request time, checked on txDone/txError.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 200;
  localparam int H   = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] txData;
  logic       txStart;
  logic       ps2ClkLow;
  logic       ps2DataLow;
  logic       txBusy;
  logic       txDone;
  logic       txError;

  logic dev_clk_low;
  logic dev_data_low;

  assign ps2Clk  = ~(ps2ClkLow  | dev_clk_low);
  assign ps2Data = ~(ps2DataLow | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2Clk     (ps2Clk),
    .ps2Data    (ps2Data),
    .txData     (txData),
    .txStart    (txStart),
    .ps2ClkLow  (ps2ClkLow),
    .ps2DataLow (ps2DataLow),
    .txBusy     (txBusy),
    .txDone     (txDone),
    .txError    (txError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         done;
    bit         err;
    logic [9:0] bits;
    logic [9:0] mask;
    int         acc;
    bit         tmo;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  logic [9:0] rx_bits;
  int         rx_n;
  int         last_fall;
  bit         abort;

  int busy_run     = 0;
  int clk_run      = 0;
  int last_clk_run = 0;

  task automatic chk(input string name, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, req);
    end
  endtask

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (!reset && (txDone || txError)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("txDone", int'(txDone), int'(mon_e.done));
        chk("txError", int'(txError), int'(mon_e.err));
        chk("frame_bits", int'(rx_bits & mon_e.mask),
            int'(mon_e.bits & mon_e.mask));
        chk("busy_run", busy_run, cyc - mon_e.acc);
        chk("inhibit_len", last_clk_run, INH);
        chk("lines_released",
            int'({ps2ClkLow, ps2DataLow}), 0);
        if (mon_e.tmo)
          chk("timeout_at", cyc, last_fall + TMO + 2);
      end
    end
    busy_run = txBusy ? busy_run + 1 : 0;
    if (ps2ClkLow) begin
      clk_run = clk_run + 1;
    end else if (clk_run > 0) begin
      last_clk_run = clk_run;
      clk_run      = 0;
    end
  end

  // Device: answers a request-to-send with nclk clock pulses.
  task automatic dev_frame(input int nclk, input bit nack);
    int k;
    rx_bits = '0;
    rx_n    = 0;
    for (k = 0; k < INH + 200 &&
         !(txBusy && !ps2ClkLow && ps2DataLow); k++)
      @(negedge clk);
    if (!(txBusy && !ps2ClkLow && ps2DataLow)) begin
      chk("request_seen", 0, 1);
      return;
    end
    repeat (H) @(negedge clk);
    for (int i = 0; i < nclk && !abort; i++) begin
      if (i == PS2_FRAME_BITS && !nack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      last_fall   = cyc;
      repeat (H) @(negedge clk);
      if (abort) break;
      dev_clk_low = 1'b0;
      if (i < PS2_FRAME_BITS) begin
        rx_bits[i] = ps2Data;
        rx_n       = i + 1;
      end
      repeat (H) @(negedge clk);
    end
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic send(input logic [7:0] b,
                      input logic [9:0] bits,
                      input logic [9:0] mask,
                      input bit ok, input bit tmo);
    exp_t e;
    e.done = ok;
    e.err  = !ok;
    e.bits = bits;
    e.mask = mask;
    e.acc  = cyc + 1;
    e.tmo  = tmo;
    sbq.push_back(e);
    txData  = b;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    txData  = 8'h00;
  endtask

  task automatic drain(input int lim);
    for (int k = 0; k < lim && sbq.size() != 0; k++)
      @(negedge clk);
    chk("queue_drained", sbq.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    txStart      = 1'b0;
    txData       = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    abort        = 1'b0;
    rx_bits      = '0;
    rx_n         = 0;
    last_fall    = 0;
    repeat (3) @(negedge clk);
    chk("rst_clkLow", int'(ps2ClkLow), 0);
    chk("rst_dataLow", int'(ps2DataLow), 0);
    chk("rst_busy", int'(txBusy), 0);
    chk("rst_done", int'(txDone), 0);
    chk("rst_error", int'(txError), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED, ack: bits 1,0,1,1,0,1,1,1 parity 1 stop 1
    send(PS2_CMD_SET_LEDS, 10'b1_1_11101101, 10'h3FF, 1, 0);
    dev_frame(11, 0);
    drain(500);

    // 0xF4, ack: parity 0
    send(PS2_CMD_ENABLE, 10'b1_0_11110100, 10'h3FF, 1, 0);
    dev_frame(11, 0);
    drain(500);

    // 0xFF, device NACKs
    send(PS2_CMD_RESET, 10'b1_1_11111111, 10'h3FF, 0, 0);
    dev_frame(11, 1);
    drain(500);
    chk("nack_idle_busy", int'(txBusy), 0);

    // 0x35, device stops after 4 clocks: bits 1,0,1,0
    send(8'h35, 10'b1_1_00110101, 10'h00F, 0, 1);
    dev_frame(4, 0);
    drain(TMO + 500);

    // 0xED with a 0x55 request mid-frame
    send(PS2_CMD_SET_LEDS, 10'b1_1_11101101, 10'h3FF, 1, 0);
    fork
      dev_frame(11, 0);
      begin
        for (int k = 0; k < 500 && rx_n < 3; k++)
          @(negedge clk);
        txData  = 8'h55;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        txData  = 8'h00;
      end
    join
    drain(500);
    chk("no_restart_busy", int'(txBusy), 0);

    // Reset while sending 0xED
    txData  = PS2_CMD_SET_LEDS;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    fork
      dev_frame(11, 0);
      begin
        for (int k = 0; k < 500 && rx_n < 1; k++)
          @(negedge clk);
        for (int k = 0; k < 100 && !ps2DataLow; k++)
          @(negedge clk);
        chk("pre_reset_dataLow", int'(ps2DataLow), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_clkLow", int'(ps2ClkLow), 0);
        chk("async_dataLow", int'(ps2DataLow), 0);
        chk("async_busy", int'(txBusy), 0);
        abort = 1'b1;
      end
    join
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;
    repeat (5) @(negedge clk);

    // Clean frame after reset
    send(PS2_CMD_SET_LEDS, 10'b1_1_11101101, 10'h3FF, 1, 0);
    dev_frame(11, 0);
    drain(500);

    chk("final_queue", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
